fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter WIDTH, default 8, byte-lane width; SHALL equal the width of the upstream asynchronous FIFO data.
REQ-002 Parameter LANES, default 4, lanes per output word; SHALL be a power of two, 2..8.
REQ-003 rclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rrstn  input  1  reset, asynchronous assert, active-low.
REQ-005 rempty  input  1  upstream FIFO empty flag, rclk domain.
REQ-006 rinc  output  1  upstream FIFO read strobe.
REQ-007 rdata  input  WIDTH  upstream FIFO read data.
REQ-008 flush  input  1  single-cycle request to emit a partially filled word.
REQ-009 out_valid  output  1  output word valid.
REQ-010 out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1.
REQ-011 out_data  output  WIDTH*LANES  packed word; the first byte received SHALL occupy lane 0, bits [WIDTH-1:0].
REQ-012 out_keep  output  LANES  lane-valid mask; bit i=1 means lane i holds data.
REQ-013 flush_done  output  1  single-cycle pulse when a flush completes.

Function
REQ-014 The block SHALL treat rdata as valid on the rclk edge after any cycle with rinc=1 and rempty=0 (one-cycle read latency); at most one read SHALL be in flight (pend flag).
REQ-015 rinc SHALL be combinational: rempty=0 AND state=RUN AND (out_valid=0 OR out_ready=1 OR cnt+pend<LANES-1); rinc SHALL never assert while rempty=1.
REQ-016 The accumulator SHALL hold cnt bytes, 0..LANES-1; an arriving byte SHALL be written to lane cnt and cnt SHALL increment.
REQ-017 When an arriving byte fills lane LANES-1, the full word SHALL load the output register in that same edge with out_keep all ones, and cnt SHALL wrap to 0.
REQ-018 The rinc rule of REQ-015 SHALL guarantee that a completing byte never meets an occupied, stalled output register; the byte SHALL never be dropped or overwritten.
REQ-019 The output register SHALL hold out_data/out_keep stable while out_valid=1 and out_ready=0; out_valid SHALL clear on acceptance unless a new word loads on the same edge.
REQ-020 State machine: RUN, FL_WAIT, FL_EMIT. RUN -> FL_WAIT on flush=1; flush SHALL be ignored outside RUN.
REQ-021 FL_WAIT: no new reads; once pend=0 -> FL_EMIT.
REQ-022 FL_EMIT with cnt=0: pulse flush_done, -> RUN, emit nothing.
REQ-023 FL_EMIT with cnt>0: once out_valid=0 or out_ready=1, load the accumulator with out_keep low cnt bits set and unused lanes zero, set cnt=0, pulse flush_done, -> RUN.
REQ-024 flush and a completing byte arriving on the same edge: the byte SHALL complete its word normally and the flush SHALL then find cnt=0.
REQ-025 Throughput SHALL be one byte per rclk cycle while rempty=0 and downstream is ready.

Reset
REQ-026 rrstn=0 SHALL asynchronously force: state=RUN, cnt=0, pend=0, out_valid=0, out_data=0, out_keep=0, flush_done=0; rinc SHALL be 0 while rrstn=0.
REQ-027 Reset mid-word or mid-flush SHALL discard the accumulator and any in-flight byte without emitting them.
REQ-028 The first rinc after reset release SHALL be permitted on the first rclk edge with rrstn=1 and rempty=0.

Verification
REQ-029 Driving FIFO 8 bytes 0x01..0x08, out_ready=1 -> two words 0x04030201 then 0x08070605, out_keep=0xF, rinc high for exactly 8 cycles.
REQ-030 Driving 16 bytes with out_ready=0 -> exactly one word held stable, rinc stops once cnt+pend reaches 3, with no lost bytes after out_ready=1: 4 words in order.
REQ-031 Driving 6 bytes 0xA0..0xA5 then flush -> 0xA3A2A1A0 keep 0xF, then 0x0000A5A4 keep 0x3, flush_done once.
REQ-032 Issuing flush with cnt=0 and no read pending -> flush_done 2 cycles later, no out_valid.
REQ-033 Asserting rrstn=0 after 2 bytes accepted -> all outputs 0 immediately; after release, next 4 bytes form a fresh word starting at lane 0.
REQ-034 Toggling out_ready randomly over 64 bytes -> output sequence equals input sequence byte-for-byte; rinc never asserted with rempty=1.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: upstream FIFO read port, flush control and packed output stream.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                     rempty;
  logic                     rinc;
  logic [WIDTH-1:0]         rdata;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*LANES-1:0]   out_data;
  logic [LANES-1:0]         out_keep;
  logic                     flush_done;
  modport master (
    input  rempty, rdata, flush, out_ready,
    output rinc, out_valid, out_data, out_keep, flush_done
  );
  modport slave (
    output rempty, rdata, flush, out_ready,
    input  rinc, out_valid, out_data, out_keep, flush_done
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs bytes read from an async FIFO (1-cycle read latency) into LANES-wide words.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input logic rclk,
  input logic rrstn,
  fifo_rd_packer_if.master bus
);
  localparam int CW = $clog2(LANES);
  localparam logic [1:0] RUN = 2'd0, FL_WAIT = 2'd1, FL_EMIT = 2'd2;
  localparam logic [CW-1:0] CNT_MAX = CW'(LANES - 1);
  localparam logic [CW:0] FILL_MAX = (CW + 1)'(LANES - 1);

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q;
  logic [WIDTH*LANES-1:0] acc_q, acc_d, acc_w, od_q, od_d;
  logic [LANES-1:0]       ok_q, ok_d;
  logic                   ov_q, ov_d;
  logic [CW:0]            fill;
  logic                   rinc, complete, emit_ok, done, flush_load;

  // Holding back reads once the accumulator plus in-flight byte could complete a
  // word guarantees a completing byte never meets a stalled output register.
  assign fill       = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
  assign rinc       = rrstn & ~bus.rempty & (state_q == RUN) & (~ov_q | bus.out_ready | (fill < FILL_MAX));
  assign complete   = pend_q & (cnt_q == CNT_MAX);
  assign emit_ok    = ~ov_q | bus.out_ready;
  assign done       = (state_q == FL_EMIT) & ((cnt_q == '0) | emit_ok);
  assign flush_load = done & (cnt_q != '0);

  always_comb begin
    acc_w = acc_q;
    if (pend_q) acc_w[cnt_q*WIDTH +: WIDTH] = bus.rdata;
  end

  always_comb begin
    cnt_d   = pend_q ? cnt_q + CW'(1) : cnt_q;
    acc_d   = acc_w;
    od_d    = od_q;
    ok_d    = ok_q;
    ov_d    = ov_q & ~bus.out_ready;
    state_d = (state_q == RUN && bus.flush) ? FL_WAIT :
              (state_q == FL_WAIT && !pend_q) ? FL_EMIT :
              (done || state_q == 2'd3) ? RUN : state_q;
    if (complete) begin
      od_d  = acc_w;
      ok_d  = '1;
      ov_d  = 1'b1;
      acc_d = '0;
    end
    if (flush_load) begin
      od_d  = acc_q;
      ok_d  = LANES'((32'd1 << cnt_q) - 32'd1);
      ov_d  = 1'b1;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      acc_q   <= '0;
      od_q    <= '0;
      ok_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= rinc;
      acc_q   <= acc_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.rinc       = rinc;
  assign bus.out_valid  = ov_q;
  assign bus.out_data   = od_q;
  assign bus.out_keep   = ok_q;
  assign bus.flush_done = done;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed scenarios against a behavioural FIFO with 1-cycle read latency.
module tb_fifo_rd_packer;
  localparam int W = 8;
  localparam int L = 4;

  logic rclk = 1'b0;
  logic rrstn = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.WIDTH(W), .LANES(L)) bus ();
  fifo_rd_packer #(.WIDTH(W), .LANES(L)) dut (.rclk(rclk), .rrstn(rrstn), .bus(bus));

  logic [7:0]  mem [0:1023];
  int          rp = 0, wp = 0;
  int          errors = 0, checks = 0;
  int          rinc_cnt = 0, fd_cnt = 0, rinc_bad = 0;
  logic [31:0] got_d [$];
  logic [3:0]  got_k [$];

  assign bus.rempty = (rp == wp);

  always @(posedge rclk)
    if (bus.rinc && !bus.rempty) begin
      bus.rdata <= mem[rp];
      rp <= rp + 1;
    end

  always @(negedge rclk) begin
    if (bus.rinc) rinc_cnt <= rinc_cnt + 1;
    if (bus.rinc && bus.rempty) rinc_bad <= rinc_bad + 1;
    if (bus.flush_done) fd_cnt <= fd_cnt + 1;
    if (bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_k.push_back(bus.out_keep);
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 1;
  endtask

  task automatic wait_words(input int n, input int base, input int lim);
    for (int i = 0; i < lim && got_d.size() < base + n; i++) tick();
    checks++;
    if (got_d.size() < base + n) begin
      errors++;
      $display("FAIL wait_words: got %0d words, required %0d", got_d.size() - base, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h want 0", bus.out_keep); end
    checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_fdone: got %b want 0", bus.flush_done); end
    checks++; if (bus.rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", bus.rinc); end
  endtask

  task automatic test_stream();
    int base, rb;
    base = got_d.size();
    rb = rinc_cnt;
    bus.out_ready = 1'b1;
    rrstn = 1'b1;
    #1;
    checks++; if (bus.rinc !== 1'b1) begin errors++; $display("FAIL first_rinc: got %b want 1", bus.rinc); end
    wait_words(2, base, 30);
    checks++; if (got_d[base] !== 32'h04030201) begin errors++; $display("FAIL stream_w0: got %h want 04030201", got_d[base]); end
    checks++; if (got_d[base+1] !== 32'h08070605) begin errors++; $display("FAIL stream_w1: got %h want 08070605", got_d[base+1]); end
    checks++; if (got_k[base] !== 4'hF || got_k[base+1] !== 4'hF) begin errors++; $display("FAIL stream_keep: got %h %h want f f", got_k[base], got_k[base+1]); end
    repeat (3) tick();
    checks++; if (rinc_cnt - rb !== 8) begin errors++; $display("FAIL stream_rinc_cycles: got %0d want 8", rinc_cnt - rb); end
  endtask

  task automatic test_backpressure();
    int base, r0;
    logic [31:0] e;
    base = got_d.size();
    r0 = rp;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    repeat (8) tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h13121110) begin errors++; $display("FAIL bp_hold1: got v=%b %h want v=1 13121110", bus.out_valid, bus.out_data); end
    repeat (6) tick();
    checks++; if (bus.out_data !== 32'h13121110 || bus.out_keep !== 4'hF) begin errors++; $display("FAIL bp_hold2: got %h/%h want 13121110/f", bus.out_data, bus.out_keep); end
    checks++; if (bus.rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc_stop: got %b want 0", bus.rinc); end
    checks++; if (rp - r0 !== 7) begin errors++; $display("FAIL bp_reads: got %0d want 7", rp - r0); end
    bus.out_ready = 1'b1;
    wait_words(4, base, 40);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) e[j*8 +: 8] = 8'(8'h10 + 4*k + j);
      checks++; if (got_d[base+k] !== e) begin errors++; $display("FAIL bp_word%0d: got %h want %h", k, got_d[base+k], e); end
    end
  endtask

  task automatic test_flush();
    int base, fb;
    base = got_d.size();
    fb = fd_cnt;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    repeat (12) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_words(2, base, 20);
    checks++; if (got_d[base] !== 32'hA3A2A1A0 || got_k[base] !== 4'hF) begin errors++; $display("FAIL flush_w0: got %h/%h want a3a2a1a0/f", got_d[base], got_k[base]); end
    checks++; if (got_d[base+1] !== 32'h0000A5A4 || got_k[base+1] !== 4'h3) begin errors++; $display("FAIL flush_w1: got %h/%h want 0000a5a4/3", got_d[base+1], got_k[base+1]); end
    repeat (3) tick();
    checks++; if (fd_cnt - fb !== 1) begin errors++; $display("FAIL flush_done_count: got %0d want 1", fd_cnt - fb); end
  endtask

  task automatic test_flush_empty();
    int base;
    base = got_d.size();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL fe_early: got %b want 0", bus.flush_done); end
    tick();
    checks++; if (bus.flush_done !== 1'b1) begin errors++; $display("FAIL fe_pulse: got %b want 1", bus.flush_done); end
    tick();
    checks++; if (bus.flush_done !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fe_after: got fd=%b v=%b want 0 0", bus.flush_done, bus.out_valid); end
    checks++; if (got_d.size() !== base) begin errors++; $display("FAIL fe_no_word: got %0d words want 0", got_d.size() - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h51 + i));
    repeat (12) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", bus.out_valid); end
    #2 rrstn = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.out_keep, bus.out_data, bus.flush_done, bus.rinc} !== 38'h0) begin errors++; $display("FAIL rm_outputs: got v=%b k=%h d=%h fd=%b ri=%b want all 0", bus.out_valid, bus.out_keep, bus.out_data, bus.flush_done, bus.rinc); end
    for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
    base = got_d.size();
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.rinc !== 1'b0) begin errors++; $display("FAIL rm_rinc_in_reset: got %b want 0", bus.rinc); end
    rrstn = 1'b1;
    wait_words(1, base, 20);
    checks++; if (got_d[base] !== 32'h64636261 || got_k[base] !== 4'hF) begin errors++; $display("FAIL rm_fresh_word: got %h/%h want 64636261/f", got_d[base], got_k[base]); end
    repeat (4) tick();
    checks++; if (got_d.size() !== base + 1) begin errors++; $display("FAIL rm_word_count: got %0d want 1", got_d.size() - base); end
  endtask

  task automatic test_random();
    int base, w0;
    logic [31:0] e;
    base = got_d.size();
    w0 = wp;
    for (int i = 0; i < 64; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 600 && got_d.size() < base + 16; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.out_ready = 1'b1;
    wait_words(16, base, 20);
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) e[j*8 +: 8] = mem[w0 + 4*k + j];
      checks++; if (got_d[base+k] !== e || got_k[base+k] !== 4'hF) begin errors++; $display("FAIL rand_word%0d: got %h/%h want %h/f", k, got_d[base+k], got_k[base+k], e); end
    end
    checks++; if (rinc_bad !== 0) begin errors++; $display("FAIL rinc_while_empty: got %0d want 0", rinc_bad); end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
